// File: rtl/rggen_bus_splitter_wd.sv
// Fans one host bus access out to TOTAL_REGISTERS register slices and merges their responses.
// Latency: 1 cycle after the first ready, or TIMEOUT_CYCLES+1 cycles when the watchdog aborts.
// Backpressure: the host holds bus_request until bus_done; slices stall the access by withholding ready.
module rggen_bus_splitter_wd #(
  parameter int ADDRESS_WIDTH         = 16,
  parameter int DATA_WIDTH            = 32,
  parameter int TOTAL_REGISTERS       = 1,
  parameter int TIMEOUT_CYCLES        = 0,
  parameter bit ERROR_ON_MULTI_SELECT = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  bus_request,
  input  logic [ADDRESS_WIDTH-1:0]              bus_address,
  input  logic                                  bus_direction,
  input  logic [DATA_WIDTH-1:0]                 bus_write_data,
  input  logic [DATA_WIDTH/8-1:0]               bus_write_strobe,
  output logic                                  bus_done,
  output logic                                  bus_read_done,
  output logic                                  bus_write_done,
  output logic [DATA_WIDTH-1:0]                 bus_read_data,
  output logic [1:0]                            bus_status,
  output logic                                  bus_timeout,
  output logic [TOTAL_REGISTERS-1:0]            register_request,
  output logic [ADDRESS_WIDTH-1:0]              register_address,
  output logic                                  register_direction,
  output logic [DATA_WIDTH-1:0]                 register_write_data,
  output logic [DATA_WIDTH-1:0]                 register_write_mask,
  input  logic [TOTAL_REGISTERS-1:0]            register_select,
  input  logic [TOTAL_REGISTERS-1:0]            register_ready,
  input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] register_read_data,
  input  logic [TOTAL_REGISTERS*2-1:0]          register_status
);

  localparam int STROBE_WIDTH = DATA_WIDTH / 8;
  // Watchdog counter keeps at least one bit so the declaration stays legal when disabled.
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [TOTAL_REGISTERS-1:0] SEL_ONE = TOTAL_REGISTERS'(1);

  localparam logic [1:0] RSP_OKAY   = 2'd0;
  localparam logic [1:0] RSP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   wd_count;
  logic [DATA_WIDTH-1:0]  merged_data;
  logic [1:0]             merged_status;
  logic                   any_select;
  logic                   multi_select;
  logic                   any_ready;
  logic                   select_error;
  logic                   watchdog_hit;

  // Request is broadcast to every slice, held off in RESP and under reset so no slice sees a repeat.
  assign register_request   = {TOTAL_REGISTERS{bus_request && !rst && (state != ST_RESP)}};
  assign register_address   = bus_address;
  assign register_direction = bus_direction;
  assign register_write_data = bus_write_data;

  // Byte strobes expanded into a per-bit write mask.
  always_comb begin
    register_write_mask = '0;
    for (int k = 0; k < STROBE_WIDTH; k++) begin
      register_write_mask[8*k +: 8] = {8{bus_write_strobe[k]}};
    end
  end

  // OR-merge of the responses from the selected slices only.
  always_comb begin
    merged_data   = '0;
    merged_status = '0;
    for (int i = 0; i < TOTAL_REGISTERS; i++) begin
      merged_data   = merged_data |
                      (register_read_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{register_select[i]}});
      merged_status = merged_status | (register_status[2*i +: 2] & {2{register_select[i]}});
    end
  end

  // Clearing the lowest set bit leaves something only when two or more selects are active.
  assign any_select   = |register_select;
  assign multi_select = |(register_select & (register_select - SEL_ONE));
  assign any_ready    = |register_ready;
  assign select_error = !any_select || (multi_select && ERROR_ON_MULTI_SELECT);
  assign watchdog_hit = (TIMEOUT_CYCLES != 0) && (wd_count == CNT_LAST);

  // Access FSM with registered response outputs; pulses live for exactly the RESP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      wd_count       <= '0;
      bus_done       <= 1'b0;
      bus_read_done  <= 1'b0;
      bus_write_done <= 1'b0;
      bus_read_data  <= '0;
      bus_status     <= RSP_OKAY;
      bus_timeout    <= 1'b0;
    end else begin
      bus_done       <= 1'b0;
      bus_read_done  <= 1'b0;
      bus_write_done <= 1'b0;
      bus_read_data  <= '0;
      bus_status     <= RSP_OKAY;
      bus_timeout    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus_request) begin
            if (select_error) begin
              state          <= ST_RESP;
              bus_done       <= 1'b1;
              bus_read_done  <= !bus_direction;
              bus_write_done <= bus_direction;
              bus_status     <= RSP_SLVERR;
            end else if (any_ready) begin
              state          <= ST_RESP;
              bus_done       <= 1'b1;
              bus_read_done  <= !bus_direction;
              bus_write_done <= bus_direction;
              bus_read_data  <= merged_data;
              bus_status     <= merged_status;
            end else begin
              state    <= ST_WAIT;
              wd_count <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (!bus_request) begin
            // Host withdrew the access: drop it silently.
            state    <= ST_IDLE;
            wd_count <= '0;
          end else if (any_ready) begin
            state          <= ST_RESP;
            bus_done       <= 1'b1;
            bus_read_done  <= !bus_direction;
            bus_write_done <= bus_direction;
            bus_read_data  <= merged_data;
            bus_status     <= merged_status;
          end else if (watchdog_hit) begin
            state          <= ST_RESP;
            bus_done       <= 1'b1;
            bus_read_done  <= !bus_direction;
            bus_write_done <= bus_direction;
            bus_status     <= RSP_SLVERR;
            bus_timeout    <= 1'b1;
          end else if ((TIMEOUT_CYCLES != 0) && (wd_count != CNT_MAX)) begin
            wd_count <= wd_count + 1'b1;
          end
        end
        ST_RESP: begin
          state    <= ST_IDLE;
          wd_count <= '0;
        end
        default: begin
          state    <= ST_IDLE;
          wd_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_bus_splitter_wd.sv
// Bench for rggen_bus_splitter_wd: instance 0 has an 8-cycle watchdog and multi-select errors,
// instance 1 has no watchdog and OR-merges multiple selects.
// Inputs driven on falling edges, outputs sampled on falling edges.
module tb_rggen_bus_splitter_wd;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            req     [2];
  logic [AW-1:0]   addr    [2];
  logic            dir     [2];
  logic [DW-1:0]   wdata   [2];
  logic [DW/8-1:0] strb    [2];
  logic            done    [2];
  logic            rdone   [2];
  logic            wdone   [2];
  logic [DW-1:0]   rdata   [2];
  logic [1:0]      status  [2];
  logic            tmo     [2];
  logic [NR-1:0]   rreq    [2];
  logic [AW-1:0]   raddr   [2];
  logic            rdir    [2];
  logic [DW-1:0]   rwdata  [2];
  logic [DW-1:0]   rmask   [2];
  logic [NR-1:0]   sel     [2];
  logic [NR-1:0]   rdy     [2];
  logic [NR*DW-1:0] srdata [2];
  logic [NR*2-1:0] sstat   [2];

  rggen_bus_splitter_wd #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TOTAL_REGISTERS(NR),
    .TIMEOUT_CYCLES(8), .ERROR_ON_MULTI_SELECT(1'b1)
  ) dut_wd (
    .clk(clk), .rst(rst),
    .bus_request(req[0]), .bus_address(addr[0]), .bus_direction(dir[0]),
    .bus_write_data(wdata[0]), .bus_write_strobe(strb[0]),
    .bus_done(done[0]), .bus_read_done(rdone[0]), .bus_write_done(wdone[0]),
    .bus_read_data(rdata[0]), .bus_status(status[0]), .bus_timeout(tmo[0]),
    .register_request(rreq[0]), .register_address(raddr[0]), .register_direction(rdir[0]),
    .register_write_data(rwdata[0]), .register_write_mask(rmask[0]),
    .register_select(sel[0]), .register_ready(rdy[0]),
    .register_read_data(srdata[0]), .register_status(sstat[0])
  );

  rggen_bus_splitter_wd #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TOTAL_REGISTERS(NR),
    .TIMEOUT_CYCLES(0), .ERROR_ON_MULTI_SELECT(1'b0)
  ) dut_or (
    .clk(clk), .rst(rst),
    .bus_request(req[1]), .bus_address(addr[1]), .bus_direction(dir[1]),
    .bus_write_data(wdata[1]), .bus_write_strobe(strb[1]),
    .bus_done(done[1]), .bus_read_done(rdone[1]), .bus_write_done(wdone[1]),
    .bus_read_data(rdata[1]), .bus_status(status[1]), .bus_timeout(tmo[1]),
    .register_request(rreq[1]), .register_address(raddr[1]), .register_direction(rdir[1]),
    .register_write_data(rwdata[1]), .register_write_mask(rmask[1]),
    .register_select(sel[1]), .register_ready(rdy[1]),
    .register_read_data(srdata[1]), .register_status(sstat[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] expand_strobe(input logic [DW/8-1:0] s);
    logic [DW-1:0] m;
    m = '0;
    for (int k = 0; k < DW/8; k++) if (s[k]) m[8*k +: 8] = 8'hFF;
    return m;
  endfunction

  // Transaction-level reference: outcome of one access from the selects, ready delay and slice data.
  task automatic model(input int w, input logic [NR-1:0] s, input int d,
                       input logic [NR*DW-1:0] rd, input logic [NR*2-1:0] st,
                       output int lat, output logic [DW-1:0] edata,
                       output logic [1:0] est, output logic eto);
    int limit;
    int nsel;
    limit = (w == 0) ? 8 : 0;
    nsel  = $countones(s);
    edata = '0; est = 2'd0; eto = 1'b0;
    if (nsel == 0 || (nsel > 1 && w == 0)) begin
      lat = 1; est = 2'd2;
    end else if (limit == 0 || d <= limit) begin
      lat = d + 1;
      for (int i = 0; i < NR; i++) begin
        if (s[i]) begin
          edata = edata | rd[i*DW +: DW];
          est   = est | st[2*i +: 2];
        end
      end
    end else begin
      lat = limit + 1; est = 2'd2; eto = 1'b1;
    end
  endtask

  // One access; caller is at a falling edge. Slices raise ready d cycles after the request cycle.
  task automatic run_txn(input string name, input int w, input logic d_dir, input logic [NR-1:0] s,
                         input int d, input logic [NR*DW-1:0] rd, input logic [NR*2-1:0] st,
                         input logic [DW/8-1:0] sb, input int exp_lat, input logic [DW-1:0] exp_data,
                         input logic [1:0] exp_st, input logic exp_to);
    int  got_lat;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    a  = AW'($urandom);
    wd = $urandom;
    req[w] = 1'b1; addr[w] = a; dir[w] = d_dir; wdata[w] = wd; strb[w] = sb;
    sel[w] = s; srdata[w] = rd; sstat[w] = st;
    rdy[w] = (d == 0) ? s : '0;
    #1;
    check({name, "_fanout"}, 128'({rreq[w], raddr[w], rdir[w], rwdata[w], rmask[w]}),
          128'({{NR{1'b1}}, a, d_dir, wd, expand_strobe(sb)}));
    got_lat = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (done[w]) begin
        got_lat = cyc;
        break;
      end
      if (cyc >= d) rdy[w] = s;
    end
    if (got_lat == 0) begin
      check({name, "_no_done"}, 128'(0), 128'(1));
    end else begin
      check({name, "_latency"}, 128'(got_lat), 128'(exp_lat));
      check({name, "_data"}, 128'(rdata[w]), 128'(exp_data));
      check({name, "_resp"}, 128'({status[w], tmo[w], rdone[w], wdone[w], rreq[w]}),
            128'({exp_st, exp_to, !d_dir, d_dir, {NR{1'b0}}}));
    end
    req[w] = 1'b0; rdy[w] = '0; sel[w] = '0;
    @(negedge clk);
    check({name, "_after"}, 128'({done[w], tmo[w], rdone[w], wdone[w], status[w], rdata[w]}), 128'(0));
  endtask

  typedef struct {
    string            name;
    int               w;
    logic             d_dir;
    logic [NR-1:0]    s;
    int               d;
    logic [NR*DW-1:0] rd;
    logic [NR*2-1:0]  st;
    logic [DW/8-1:0]  sb;
    int               lat;
    logic [DW-1:0]    data;
    logic [1:0]       est;
    logic             eto;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [NR-1:0]    rs;
    logic [NR*DW-1:0] rrd;
    logic [NR*2-1:0]  rst_v;
    int               rdl;
    int               mlat;
    logic [DW-1:0]    mdata;
    logic [1:0]       mst;
    logic             mto;

    vecs[0] = '{"rd_hit", 0, 1'b0, 4'b0010, 0,
                {32'hFFFF0000, 32'h0F0F0F0F, 32'hA5A50001, 32'h12345678}, 8'hF3, 4'hF,
                1, 32'hA5A50001, 2'd0, 1'b0};
    vecs[1] = '{"wr_unmapped", 0, 1'b1, 4'b0000, 0,
                {32'h1, 32'h2, 32'h3, 32'h4}, 8'h00, 4'b0101, 1, 32'h0, 2'd2, 1'b0};
    vecs[2] = '{"wd_timeout", 0, 1'b0, 4'b0001, NEVER,
                {32'h0, 32'h0, 32'h0, 32'h11}, 8'h00, 4'hF, 9, 32'h0, 2'd2, 1'b1};
    vecs[3] = '{"rd_after_tmo", 0, 1'b0, 4'b0001, 0,
                {32'h0, 32'h0, 32'h0, 32'hCAFE0001}, 8'h00, 4'hF, 1, 32'hCAFE0001, 2'd0, 1'b0};
    vecs[4] = '{"ready_at_last", 0, 1'b0, 4'b0001, 8,
                {32'h0, 32'h0, 32'h0, 32'h00001234}, 8'h00, 4'hF, 9, 32'h00001234, 2'd0, 1'b0};
    vecs[5] = '{"multi_err", 0, 1'b0, 4'b0110, 0,
                {32'h0, 32'h000000F0, 32'h00000F00, 32'h0}, 8'h00, 4'hF, 1, 32'h0, 2'd2, 1'b0};
    vecs[6] = '{"multi_or", 1, 1'b0, 4'b0110, 0,
                {32'h0, 32'h000000F0, 32'h00000F00, 32'h0}, 8'h00, 4'hF, 1, 32'h00000FF0, 2'd0, 1'b0};
    vecs[7] = '{"wr_exokay", 0, 1'b1, 4'b0100, 3,
                {32'h0, 32'h77770000, 32'h0, 32'h0}, 8'b00_01_00_00, 4'b0011, 4, 32'h77770000, 2'd1, 1'b0};
    vecs[8] = '{"no_wd_long", 1, 1'b0, 4'b1000, 20,
                {32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, 8'b10_00_00_00, 4'hF, 21, 32'hDEADBEEF, 2'd2, 1'b0};

    for (int w = 0; w < 2; w++) begin
      req[w] = 1'b1; addr[w] = '0; dir[w] = 1'b0; wdata[w] = '0; strb[w] = '0;
      sel[w] = 4'b0001; rdy[w] = 4'b0001; srdata[w] = '1; sstat[w] = '1;
    end

    // Reset state, with a live request and ready slice on the inputs.
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check($sformatf("reset_state%0d", w),
            128'({done[w], rdone[w], wdone[w], tmo[w], status[w], rdata[w], rreq[w]}), 128'(0));
      req[w] = 1'b0; sel[w] = '0; rdy[w] = '0;
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, issued back to back.
    for (int v = 0; v < 9; v++) begin
      run_txn(vecs[v].name, vecs[v].w, vecs[v].d_dir, vecs[v].s, vecs[v].d, vecs[v].rd,
              vecs[v].st, vecs[v].sb, vecs[v].lat, vecs[v].data, vecs[v].est, vecs[v].eto);
    end

    // Reset while an access is waiting: no pulse, request drops immediately.
    req[0] = 1'b1; dir[0] = 1'b0; sel[0] = 4'b0001; rdy[0] = '0;
    repeat (4) @(negedge clk);
    check("wait_before_reset", 128'({done[0], rreq[0]}), 128'({1'b0, 4'hF}));
    rst = 1'b1;
    #1;
    check("reset_mid_req", 128'({rreq[0], done[0], status[0], rdata[0]}), 128'(0));
    repeat (2) begin
      @(negedge clk);
      check("reset_mid_done", 128'({done[0], tmo[0], rdone[0]}), 128'(0));
    end
    req[0] = 1'b0; sel[0] = '0;
    rst = 1'b0;
    @(negedge clk);
    check("after_reset_quiet", 128'({done[0], tmo[0]}), 128'(0));
    run_txn("post_reset", 0, 1'b0, 4'b0100, 0, {32'h0, 32'h600D0001, 32'h0, 32'h0}, 8'h00, 4'hF,
            1, 32'h600D0001, 2'd0, 1'b0);

    // Randomised accesses against the transaction model.
    for (int w = 0; w < 2; w++) begin
      for (int n = 0; n < 25; n++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 2)      rs = '0;
        else if (r < 5) rs = NR'($urandom_range(1, 15));
        else            rs = NR'(1 << $urandom_range(0, NR - 1));
        if (w == 0 && $urandom_range(0, 4) == 0) rdl = NEVER;
        else rdl = int'($urandom_range(0, 12));
        rrd   = {$urandom, $urandom, $urandom, $urandom};
        rst_v = NR*2'($urandom);
        model(w, rs, rdl, rrd, rst_v, mlat, mdata, mst, mto);
        run_txn($sformatf("rand%0d_%0d", w, n), w, 1'($urandom), rs, rdl, rrd, rst_v,
                4'($urandom), mlat, mdata, mst, mto);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
